// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM status and memory arbiter state encodings.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISERV  = 2'd1,
      DREAD  = 2'd2,
      DWRITE = 2'd3
   } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive data grants while a fetch waits.
module starve_counter #(
   parameter int LIMIT = 4
) (
   input  logic CLK,
   input  logic nRST,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt;

   // clear takes priority over increment
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LIM)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign at_limit = (cnt == LIM);

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates one RAM port between the icache and dcache,
// with a bounded starvation guard for instruction fetches.
module ram_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  ramstate_t   ramstate
);

   arb_state_t state, nstate;
   logic inc, clr, at_limit;
   logic dreq, acc;

   assign dreq = dWEN | dREN;
   assign acc  = (ramstate == ACCESS);

   starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
      .CLK      (CLK),
      .nRST     (nRST),
      .inc      (inc),
      .clr      (clr),
      .at_limit (at_limit)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= nstate;
   end

   // a dropped request aborts back to IDLE without completing
   always_comb begin
      nstate = state;
      inc    = 1'b0;
      clr    = 1'b0;
      unique case (state)
         IDLE: begin
            if (dreq && !(iREN && at_limit)) begin
               nstate = dWEN ? DWRITE : DREAD;
               inc    = iREN;
               clr    = !iREN;
            end else if (iREN) begin
               nstate = ISERV;
               clr    = 1'b1;
            end
         end
         ISERV:  if (!iREN || acc) nstate = IDLE;
         DREAD:  if (!dREN || acc) nstate = IDLE;
         DWRITE: if (!dWEN || acc) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      unique case (state)
         IDLE: ;
         ISERV: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (iREN && acc) begin
               iwait = 1'b0;
               iload = ramload;
            end
         end
         DREAD: begin
            ramREN  = 1'b1;
            ramaddr = daddr;
            if (dREN && acc) begin
               dwait = 1'b0;
               dload = ramload;
            end
         end
         DWRITE: begin
            ramWEN   = 1'b1;
            ramaddr  = daddr;
            ramstore = dstore;
            if (dWEN && acc) dwait = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter against a transaction-level model.
module tb_ram_arbiter;
   import cpu_types_pkg::*;

   localparam int LIM = 4;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
   logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
   ramstate_t   ramstate = FREE;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic        iwait, dwait, ramREN, ramWEN;

   always #5 CLK = ~CLK;

   ram_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: who owns the RAM (0 none, 1 fetch, 2 read, 3 write)
   int srv = 0;
   int streak = 0;
   int ilow = 0, dlow = 0;
   logic [31:0] icap = '0, dcap = '0;
   int order[$];

   always @(negedge CLK) begin : cmp
      int srv_n, streak_n;
      bit req, done;
      logic e_ren, e_wen, e_iw, e_dw;
      logic [31:0] e_addr, e_store, e_il, e_dl;
      srv_n = srv; streak_n = streak;
      e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
      e_addr = '0; e_store = '0; e_il = '0; e_dl = '0;
      req = 0; done = 0;
      if (!nRST) begin
         srv_n = 0; streak_n = 0;
      end else if (srv == 0) begin
         if ((dWEN || dREN) && !(iREN && streak == LIM)) begin
            srv_n = dWEN ? 3 : 2;
            streak_n = iREN ? ((streak + 1 > LIM) ? LIM : streak + 1) : 0;
         end else if (iREN) begin
            srv_n = 1; streak_n = 0;
         end
      end else begin
         req = (srv == 1) ? iREN : (srv == 2) ? dREN : dWEN;
         done = req && (ramstate == ACCESS);
         e_addr = (srv == 1) ? iaddr : daddr;
         e_ren = (srv != 3);
         e_wen = (srv == 3);
         if (srv == 3) e_store = dstore;
         if (done && srv == 1) begin e_iw = 0; e_il = ramload; end
         if (done && srv == 2) begin e_dw = 0; e_dl = ramload; end
         if (done && srv == 3) e_dw = 0;
         if (!req || done) srv_n = 0;
      end
      chk("iwait", 32'(iwait), 32'(e_iw));
      chk("dwait", 32'(dwait), 32'(e_dw));
      chk("ramREN", 32'(ramREN), 32'(e_ren));
      chk("ramWEN", 32'(ramWEN), 32'(e_wen));
      chk("ramaddr", ramaddr, e_addr);
      chk("ramstore", ramstore, e_store);
      chk("iload", iload, e_il);
      chk("dload", dload, e_dl);
      if (!iwait) begin ilow++; icap = iload; order.push_back(1); end
      if (!dwait) begin dlow++; dcap = dload; order.push_back(2); end
      srv = srv_n;
      streak = streak_n;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic xact(input int busy);
      step(1);
      ramstate = BUSY;
      step(busy);
      ramstate = ACCESS;
      step(1);
      ramstate = FREE;
   endtask

   task automatic clr_mon();
      ilow = 0; dlow = 0; icap = '0; dcap = '0;
      order.delete();
   endtask

   initial begin
      step(2);
      chk("rst_iwait", 32'(iwait), 32'd1);
      chk("rst_dwait", 32'(dwait), 32'd1);
      chk("rst_ramREN", 32'(ramREN), 32'd0);
      nRST = 1'b1;
      step(1);

      // single fetch, two BUSY cycles
      clr_mon();
      iREN = 1; iaddr = 32'h40; ramload = 32'h8C010004;
      step(1);
      ramstate = BUSY;
      step(2);
      ramstate = ACCESS;
      step(1);
      iREN = 0; ramstate = FREE;
      step(1);
      chk("fetch_ilow", 32'(ilow), 32'd1);
      chk("fetch_iload", icap, 32'h8C010004);
      chk("fetch_dlow", 32'(dlow), 32'd0);

      // data write
      clr_mon();
      dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
      step(1);
      ramstate = BUSY;
      @(negedge CLK);
      chk("wr_ramWEN", 32'(ramWEN), 32'd1);
      chk("wr_ramaddr", ramaddr, 32'h100);
      chk("wr_ramstore", ramstore, 32'hDEADBEEF);
      step(1);
      ramstate = ACCESS;
      step(1);
      dWEN = 0; ramstate = FREE;
      step(1);
      chk("wr_dlow", 32'(dlow), 32'd1);

      // write beats read when both are raised
      clr_mon();
      dWEN = 1; dREN = 1; daddr = 32'h104;
      step(1);
      @(negedge CLK);
      chk("wr_pri_WEN", 32'(ramWEN), 32'd1);
      chk("wr_pri_REN", 32'(ramREN), 32'd0);
      step(1);
      ramstate = ACCESS;
      step(1);
      dWEN = 0; dREN = 0; ramstate = FREE;
      step(1);

      // ERROR is retried
      clr_mon();
      iREN = 1; iaddr = 32'h48; ramload = 32'hA5A5A5A5;
      step(1);
      ramstate = ERROR;
      step(2);
      chk("err_hold", 32'(ilow), 32'd0);
      ramstate = ACCESS;
      step(1);
      iREN = 0; ramstate = FREE;
      step(1);
      chk("err_done", 32'(ilow), 32'd1);
      chk("err_iload", icap, 32'hA5A5A5A5);

      // simultaneous: data first, then fetch
      clr_mon();
      iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h200;
      ramload = 32'h11111111;
      xact(1);
      dREN = 0; ramload = 32'h22222222;
      xact(1);
      iREN = 0;
      step(1);
      chk("sim_n", 32'(order.size()), 32'd2);
      if (order.size() == 2) begin
         chk("sim_first", 32'(order[0]), 32'd2);
         chk("sim_second", 32'(order[1]), 32'd1);
      end
      chk("sim_dload", dcap, 32'h11111111);
      chk("sim_iload", icap, 32'h22222222);

      // starvation: four data grants, then the fetch
      clr_mon();
      iREN = 1; dREN = 1; iaddr = 32'h50; daddr = 32'h300;
      for (int i = 0; i < 5; i++) begin
         xact(0);
         if (i == 3) chk("starve_cnt4", 32'(dut.u_starve.cnt), 32'd4);
      end
      iREN = 0; dREN = 0;
      step(1);
      chk("starve_n", 32'(order.size()), 32'd5);
      if (order.size() == 5) begin
         for (int i = 0; i < 4; i++) chk("starve_data", 32'(order[i]), 32'd2);
         chk("starve_fetch", 32'(order[4]), 32'd1);
      end
      chk("starve_cnt0", 32'(dut.u_starve.cnt), 32'd0);

      // abort after one BUSY cycle
      clr_mon();
      dREN = 1; daddr = 32'h400; ramload = 32'h33333333;
      step(1);
      ramstate = BUSY;
      step(1);
      dREN = 0;
      step(1);
      ramstate = ACCESS;
      step(2);
      ramstate = FREE;
      chk("abort_dlow", 32'(dlow), 32'd0);
      chk("abort_none", 32'(order.size()), 32'd0);
      chk("abort_state", 32'(dut.state), 32'(IDLE));

      // reset during a write
      clr_mon();
      dWEN = 1; daddr = 32'h500; dstore = 32'h12345678;
      step(1);
      ramstate = BUSY;
      step(1);
      nRST = 0;
      #1;
      chk("rst_mid_WEN", 32'(ramWEN), 32'd0);
      chk("rst_mid_addr", ramaddr, 32'd0);
      chk("rst_mid_iwait", 32'(iwait), 32'd1);
      chk("rst_mid_dwait", 32'(dwait), 32'd1);
      chk("rst_mid_state", 32'(dut.state), 32'(IDLE));
      step(1);
      dWEN = 0; nRST = 1; ramstate = ACCESS;
      step(2);
      ramstate = FREE;
      step(1);
      chk("rst_mid_dlow", 32'(dlow), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 4, giving the maximum number of consecutive data grants while an instruction request waits.
REQ-002 The module SHALL have port CLK, input, 1, system clock.
REQ-003 The module SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port iREN, input, 1, icache read request.
REQ-005 The module SHALL have port iaddr, input, 32, icache word address.
REQ-006 The module SHALL have port iload, output, 32, instruction word returned.
REQ-007 The module SHALL have port iwait, output, 1, icache stall; 0 for one cycle means iload is valid.
REQ-008 The module SHALL have port dREN, input, 1, dcache read request.
REQ-009 The module SHALL have port dWEN, input, 1, dcache write request.
REQ-010 The module SHALL have port daddr, input, 32, dcache word address.
REQ-011 The module SHALL have port dstore, input, 32, write data.
REQ-012 The module SHALL have port dload, output, 32, read data returned.
REQ-013 The module SHALL have port dwait, output, 1, dcache stall; 0 for one cycle means completion.
REQ-014 The module SHALL have port ramREN, output, 1, RAM read strobe.
REQ-015 The module SHALL have port ramWEN, output, 1, RAM write strobe.
REQ-016 The module SHALL have port ramaddr, output, 32, RAM address.
REQ-017 The module SHALL have port ramstore, output, 32, RAM write data.
REQ-018 The module SHALL have port ramload, input, 32, RAM read data.
REQ-019 The module SHALL have port ramstate, input, ramstate_t, RAM status: FREE, BUSY, ACCESS, ERROR.

Function
REQ-020 The FSM SHALL have states IDLE, ISERV, DREAD and DWRITE.
REQ-021 In IDLE, all RAM strobes SHALL be 0, and iwait and dwait SHALL be 1.
REQ-022 In IDLE with dWEN=1, the next state SHALL be DWRITE; dWEN wins over dREN if both are asserted.
REQ-023 In IDLE with dREN=1 and no write, the next state SHALL be DREAD.
REQ-024 In IDLE with only iREN=1, the next state SHALL be ISERV.
REQ-025 When iREN and a data request are both asserted in IDLE:
- data SHALL win unless the starvation counter equals STARVE_LIMIT;
- if it equals STARVE_LIMIT, ISERV SHALL win.
REQ-026 The starvation counter SHALL increment, saturating at STARVE_LIMIT, on each data grant made while iREN=1.
REQ-027 The starvation counter SHALL clear on every ISERV grant and on any data grant made while iREN=0.
REQ-028 In ISERV, ramREN SHALL be 1 and ramaddr SHALL equal iaddr; ramWEN SHALL be 0.
REQ-029 In DREAD, ramREN SHALL be 1 and ramaddr SHALL equal daddr.
REQ-030 In DWRITE, ramWEN SHALL be 1, ramaddr SHALL equal daddr, and ramstore SHALL equal dstore.
REQ-031 Address and data SHALL be driven combinationally from the live inputs; requesters hold them stable while their wait is 1.
REQ-032 In a service state with ramstate=ACCESS, the granted side's wait SHALL be 0 in that same cycle, and the next state SHALL be IDLE.
REQ-033 During that ACCESS cycle, iload or dload SHALL equal ramload.
REQ-034 The non-granted wait SHALL remain 1 at all times.
REQ-035 Minimum latency from request to completion SHALL be 2 cycles: 1 cycle in IDLE plus 1 ACCESS cycle.
REQ-036 In a service state with ramstate of BUSY, FREE or ERROR, the FSM SHALL stay in that state with the wait held at 1; ERROR is retried.
REQ-037 If the granted request deasserts before ACCESS (abort):
- the next state SHALL be IDLE;
- no wait SHALL drop;
- the starvation counter SHALL be unchanged.
REQ-038 iload and dload SHALL be 0 whenever their wait is 1.

Reset
REQ-039 nRST low SHALL asynchronously force state IDLE and starvation counter 0.
REQ-040 While nRST is low, outputs SHALL be iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
REQ-041 Reset asserted mid-transaction SHALL abandon that transaction without any wait dropping.

Structure
REQ-042 ramstate_t and the FSM state enum arb_state_t SHALL be defined in cpu_types_pkg.
REQ-043 The starvation counter SHALL be sub-module starve_counter, which is a parameterised saturating counter with inc and clr inputs and an at_limit output.
REQ-044 All other logic SHALL reside in ram_arbiter as one registered-state FSM with combinational outputs.

Verification
REQ-045 The bench SHALL cover a single instruction read: iREN=1, iaddr=0x40, RAM with 2 BUSY cycles, then ACCESS with ramload=0x8C010004 -> iwait=0 for exactly 1 cycle with iload=0x8C010004 in that cycle, and dwait=1 throughout.
REQ-046 The bench SHALL cover a data write: dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF until ACCESS, then dwait=0 for 1 cycle.
REQ-047 The bench SHALL cover simultaneous requests: iREN=1 and dREN=1 in IDLE -> DREAD granted first, then ISERV after it completes if iREN is still 1.
REQ-048 The bench SHALL cover starvation: iREN held at 1 while dREN is re-asserted every IDLE, STARVE_LIMIT=4 -> 4 data grants, then an instruction grant, with the counter back at 0.
REQ-049 The bench SHALL cover abort: dREN dropped after 1 BUSY cycle in DREAD -> return to IDLE, dwait stays 1, and no dload is returned.
REQ-050 The bench SHALL cover reset mid-service: nRST pulsed low in DWRITE -> immediate ramWEN=0, state IDLE, and both waits 1.
